// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the fetch port and the data port.
// Data has fixed priority, one transaction in flight, registered bus outputs, bounded wait.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_sel_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_ack_o,
    output logic                  err_o,
    input  logic                  flush_i,
    output logic                  bus_stb_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  stallreq_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUS_IF = 2'd1;
    localparam logic [1:0] S_BUS_D  = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;
    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                discard_q, discard_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [DATA_W/8-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                err_q, err_d;
    logic                drop_fetch;
    logic                timeout_hit;

    // A flush on the completing edge of a fetch already counts as a discard.
    assign drop_fetch  = discard_q | flush_i;
    assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == TIMEOUT_C;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        discard_d  = discard_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (d_req_i) begin
                    we_d    = d_we_i;
                    sel_d   = d_sel_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    stb_d   = 1'b1;
                    state_d = S_BUS_D;
                end else if (if_req_i) begin
                    we_d    = 1'b0;
                    sel_d   = '1;
                    addr_d  = if_addr_i;
                    stb_d   = 1'b1;
                    state_d = S_BUS_IF;
                end
            end
            S_BUS_IF, S_BUS_D: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (state_q == S_BUS_IF) begin
                    discard_d = drop_fetch;
                end
                if (bus_ack_i || timeout_hit) begin
                    stb_d   = 1'b0;
                    state_d = S_ACK;
                    if (state_q == S_BUS_IF) begin
                        if (!drop_fetch) begin
                            if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
                            if_ack_d   = 1'b1;
                            err_d      = ~bus_ack_i;
                        end
                    end else begin
                        d_ack_d = 1'b1;
                        err_d   = ~bus_ack_i;
                        if (!bus_ack_i) begin
                            d_rdata_d = '0;
                        end else if (!we_q) begin
                            d_rdata_d = bus_rdata_i;
                        end
                    end
                end
            end
            default: begin
                discard_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            discard_q  <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
        end
    end

    // A flush arriving in the fetch ack cycle still kills the ack.
    assign if_ack_o    = if_ack_q & ~flush_i;
    assign d_ack_o     = d_ack_q;
    assign err_o       = err_q & (if_ack_o | d_ack_o);
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign bus_stb_o   = stb_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign stallreq_o  = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, d_req_i, d_we_i, flush_i, bus_ack_i;
    logic [AW-1:0] if_addr_i, d_addr_i;
    logic [3:0]    d_sel_i;
    logic [DW-1:0] d_wdata_i, bus_rdata_i;
    logic [DW-1:0] if_rdata_o, d_rdata_o, bus_wdata_o;
    logic [AW-1:0] bus_addr_o;
    logic [3:0]    bus_sel_o;
    logic          if_ack_o, d_ack_o, err_o, bus_stb_o, bus_we_o, stallreq_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .err_o(err_o),
        .flush_i(flush_i), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o)
    );

    int total = 0;
    int bad   = 0;

    // Transaction-level model: one outstanding grant, then a single completion cycle.
    bit            m_busy, m_data, m_drop, m_fin, m_fin_data, m_fin_to, m_fin_drop;
    int            m_wait;
    logic          m_stb, m_we;
    logic [3:0]    m_sel;
    logic [31:0]   m_addr, m_wdata, m_if_rdata, m_d_rdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit e_if_ack();
        return m_fin && !m_fin_data && !m_fin_drop && !flush_i;
    endfunction
    function automatic bit e_d_ack();
        return m_fin && m_fin_data;
    endfunction
    function automatic bit e_err();
        return m_fin_to && (e_if_ack() || e_d_ack());
    endfunction
    function automatic bit e_stall();
        return (if_req_i && !e_if_ack()) || (d_req_i && !e_d_ack());
    endfunction

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_fin = 0; m_drop = 0; m_wait = 0;
            m_stb = 0; m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0;
            m_if_rdata = 0; m_d_rdata = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (!m_busy) begin
            if (d_req_i) begin
                m_busy = 1; m_data = 1;
                m_we = d_we_i; m_sel = d_sel_i; m_addr = d_addr_i; m_wdata = d_wdata_i;
            end else if (if_req_i) begin
                m_busy = 1; m_data = 0;
                m_we = 0; m_sel = 4'hF; m_addr = if_addr_i;
            end
            if (m_busy) begin
                m_stb = 1; m_wait = 0; m_drop = 0;
            end
        end else begin
            m_wait++;
            if (!m_data && flush_i) m_drop = 1;
            if (bus_ack_i || m_wait == TO) begin
                m_fin = 1; m_busy = 0; m_stb = 0;
                m_fin_data = m_data; m_fin_drop = m_drop; m_fin_to = !bus_ack_i;
                if (m_data) begin
                    if (!bus_ack_i) m_d_rdata = 0;
                    else if (!m_we) m_d_rdata = bus_rdata_i;
                end else if (!m_drop) begin
                    m_if_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("bus_stb", bus_stb_o, m_stb);
        chk("bus_we", bus_we_o, m_we);
        chk("bus_sel", bus_sel_o, m_sel);
        chk("bus_addr", bus_addr_o, m_addr);
        chk("bus_wdata", bus_wdata_o, m_wdata);
        chk("if_rdata", if_rdata_o, m_if_rdata);
        chk("d_rdata", d_rdata_o, m_d_rdata);
        chk("if_ack", if_ack_o, e_if_ack());
        chk("d_ack", d_ack_o, e_d_ack());
        chk("err", err_o, e_err());
        chk("stallreq", stallreq_o, e_stall());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic new_data();
        d_we_i    = 1'($urandom_range(1, 0));
        d_sel_i   = 4'($urandom_range(15, 1));
        d_addr_i  = $urandom & 32'hFFFF_FFFC;
        d_wdata_i = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_sel_i = 0;
        d_addr_i = 0; d_wdata_i = 0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
        tick(); tick();
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_addr", bus_addr_o, 0);
        chk("rst_ack", {if_ack_o, d_ack_o, err_o}, 0);

        // Zero-wait fetch
        rst = 0; if_req_i = 1; if_addr_i = 32'h4; settle();
        chk("zw_stall", stallreq_o, 1);
        tick();
        chk("zw_stb", bus_stb_o, 1); chk("zw_addr", bus_addr_o, 32'h4);
        chk("zw_we", bus_we_o, 0);   chk("zw_sel", bus_sel_o, 4'hF);
        bus_ack_i = 1; bus_rdata_i = 32'h3401_0001; settle();
        tick();
        chk("zw_ack", if_ack_o, 1); chk("zw_rdata", if_rdata_o, 32'h3401_0001);
        chk("zw_stb_drop", bus_stb_o, 0);
        if_req_i = 0; bus_ack_i = 0; settle();
        tick();
        chk("zw_ack_end", if_ack_o, 0);

        // Simultaneous requests: data wins, fetch granted 2 cycles after bus ack
        if_req_i = 1; if_addr_i = 32'h8;
        d_req_i = 1; d_we_i = 1; d_sel_i = 4'h3; d_addr_i = 32'h80; d_wdata_i = 32'hDEAD_BEEF;
        settle(); tick();
        chk("sim_we", bus_we_o, 1); chk("sim_sel", bus_sel_o, 4'h3);
        chk("sim_addr", bus_addr_o, 32'h80); chk("sim_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        bus_ack_i = 1; settle(); tick();
        chk("sim_dack", d_ack_o, 1); chk("sim_drdata", d_rdata_o, 0);
        d_req_i = 0; bus_ack_i = 0; settle(); tick();
        chk("sim_gap", bus_stb_o, 0);
        tick();
        chk("sim_if_stb", bus_stb_o, 1); chk("sim_if_addr", bus_addr_o, 32'h8);
        bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D; settle(); tick();
        chk("sim_if_ack", if_ack_o, 1);
        if_req_i = 0; bus_ack_i = 0; settle(); tick();

        // Wait states: ack lands exactly on the timeout edge and must win
        d_req_i = 1; d_we_i = 0; d_sel_i = 4'hF; d_addr_i = 32'h100; settle(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ws_stb", bus_stb_o, 1); chk("ws_addr", bus_addr_o, 32'h100);
        end
        bus_ack_i = 1; bus_rdata_i = 32'h1122_3344; settle(); tick();
        chk("ws_dack", d_ack_o, 1); chk("ws_err", err_o, 0);
        chk("ws_rdata", d_rdata_o, 32'h1122_3344);
        d_req_i = 0; bus_ack_i = 0; settle(); tick();

        // Timeout
        d_req_i = 1; d_addr_i = 32'h200; settle(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("to_stb", bus_stb_o, 1);
        end
        tick();
        chk("to_stb_drop", bus_stb_o, 0); chk("to_dack", d_ack_o, 1);
        chk("to_err", err_o, 1); chk("to_rdata", d_rdata_o, 0);
        d_req_i = 0; settle(); tick();
        chk("to_err_end", err_o, 0);

        // Flush during BUS_IF, then a normal fetch
        if_req_i = 1; if_addr_i = 32'h20; settle(); tick();
        flush_i = 1; settle(); tick();
        flush_i = 0; settle(); tick(); tick();
        bus_ack_i = 1; bus_rdata_i = 32'h5555_5555; settle(); tick();
        chk("fl_ack", if_ack_o, 0); chk("fl_rdata", if_rdata_o, 32'h0BAD_F00D);
        if_addr_i = 32'h24; bus_ack_i = 0; settle(); tick(); tick();
        chk("fl_next_addr", bus_addr_o, 32'h24);
        bus_ack_i = 1; bus_rdata_i = 32'h77; settle(); tick();
        chk("fl_next_ack", if_ack_o, 1); chk("fl_next_rdata", if_rdata_o, 32'h77);
        if_req_i = 0; bus_ack_i = 0; settle(); tick();

        // Flush in the fetch ack cycle masks the ack combinationally
        if_req_i = 1; if_addr_i = 32'h28; settle(); tick();
        bus_ack_i = 1; bus_rdata_i = 32'h99; settle(); tick();
        flush_i = 1; if_req_i = 0; bus_ack_i = 0; settle();
        chk("fa_ack", if_ack_o, 0);
        flush_i = 0; settle(); tick();

        // Reset mid-transaction
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h300; d_wdata_i = 32'h1234_5678; settle(); tick();
        chk("rm_stb", bus_stb_o, 1);
        tick();
        rst = 1; settle(); tick();
        chk("rm_stb_drop", bus_stb_o, 0); chk("rm_dack", d_ack_o, 0);
        chk("rm_addr", bus_addr_o, 0); chk("rm_rdata", d_rdata_o, 0);
        rst = 0; d_req_i = 0; settle(); tick();
        chk("rm_dack_after", d_ack_o, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int p_ack;
            p_ack = (c < 1500) ? 35 : ((c < 2500) ? 5 : 80);
            tick();
            if (m_fin && m_fin_data) begin
                if ($urandom_range(1, 0) == 1) d_req_i = 0;
                else new_data();
            end else if (!d_req_i && $urandom_range(99, 0) < 30) begin
                d_req_i = 1;
                new_data();
            end
            if (m_fin && !m_fin_data) begin
                if ($urandom_range(1, 0) == 1) if_req_i = 0;
                else if_addr_i = if_addr_i + 32'd4;
            end else if (!if_req_i && $urandom_range(99, 0) < 50) begin
                if_req_i  = 1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            flush_i = ($urandom_range(99, 0) < 8);
            if (flush_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
            bus_ack_i   = ($urandom_range(99, 0) < p_ack);
            bus_rdata_i = $urandom;
            rst         = ($urandom_range(999, 0) < 3);
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
